// File: rtl/div_pipe_pkg.sv
// Shared types for the DIV execution pipe: request/response bundles,
// operation encoding, FSM states and small helpers.
package div_pipe_pkg;

    localparam int XLEN = 32;
    localparam int EXE_PIPE_ID_DIV = 3;

    // bit1 = remainder, bit0 = unsigned
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        div_op_e         div_control;
    } ix_div_inf_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
    } div_wb_inf_t;

    typedef enum logic [1:0] {
        DIV_ST_IDLE,
        DIV_ST_CALC,
        DIV_ST_FIXUP,
        DIV_ST_DONE
    } div_state_e;

    // Magnitude of a signed operand; unsigned operands pass through.
    function automatic logic [XLEN-1:0] abs_op(
        input logic [XLEN-1:0] v,
        input logic            sgn
    );
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// Single-bit restoring division step (combinational).
// rem_i/dvd_i/dvs_i/q_i in -> rem_o/dvd_o/q_o out.
module div_iter_step
    import div_pipe_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] dvd_i,
    input  logic [XLEN-1:0] dvs_i,
    // top quotient bit shifts out, so only the low bits are needed
    input  logic [XLEN-2:0] q_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] dvd_o,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;
    logic          ge;

    always_comb begin
        rem_sh = {rem_i[XLEN-1:0], dvd_i[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_i};
        // a set rem_i MSB means the shifted value exceeds any divisor
        ge     = rem_i[XLEN] | (rem_sh >= {1'b0, dvs_i});
        rem_o  = ge ? diff : rem_sh;
        dvd_o  = {dvd_i[XLEN-2:0], 1'b0};
        q_o    = {q_i, ge};
    end

endmodule

// File: rtl/div_pipe.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU), one op in flight.
// IX request in (valid/ready), WB response out (valid/ready), flush, busy.
module div_pipe
    import div_pipe_pkg::*;
#(
    parameter bit FAST_SPECIAL = 1'b1,
    parameter int ITER_COUNT   = XLEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ix_div_valid_i,
    output logic        ix_div_ready_o,
    input  ix_div_inf_t ix_div_inf_i,
    input  logic        flush_i,
    output logic        div_wb_valid_o,
    input  logic        div_wb_ready_i,
    output div_wb_inf_t div_wb_inf_o,
    output logic        busy_o
);

    localparam int CW = $clog2(ITER_COUNT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ITER_COUNT - 1);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [4:0]      rd_q, rd_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;

    logic            accept;
    logic            sgn;
    logic            is_rem;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] spec_res;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_dvd;
    logic [XLEN-1:0] step_q;

    div_iter_step u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dvs_i (dvs_q),
        .q_i   (quo_q[XLEN-2:0]),
        .rem_o (step_rem),
        .dvd_o (step_dvd),
        .q_o   (step_q)
    );

    always_comb begin
        sgn      = ~ix_div_inf_i.div_control[0];
        is_rem   = ix_div_inf_i.div_control[1];
        accept   = ix_div_valid_i & ix_div_ready_o & ~flush_i;
        div_zero = (ix_div_inf_i.rs2 == '0);
        ovf      = sgn && (ix_div_inf_i.rs1 == 32'h8000_0000)
                       && (ix_div_inf_i.rs2 == 32'hFFFF_FFFF);
        special  = FAST_SPECIAL && (div_zero || ovf);
        if (div_zero)
            spec_res = is_rem ? ix_div_inf_i.rs1 : 32'hFFFF_FFFF;
        else
            spec_res = is_rem ? 32'h0 : 32'h8000_0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DIV_ST_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            res_q    <= '0;
            rd_q     <= '0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            res_q    <= res_d;
            rd_q     <= rd_d;
            is_rem_q <= is_rem_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = DIV_ST_IDLE;
        end else begin
            unique case (state_q)
                DIV_ST_IDLE:
                    if (accept)
                        state_d = special ? DIV_ST_DONE : DIV_ST_CALC;
                DIV_ST_CALC:
                    if (cnt_q == '0)
                        state_d = DIV_ST_FIXUP;
                DIV_ST_FIXUP:
                    state_d = DIV_ST_DONE;
                DIV_ST_DONE:
                    if (div_wb_ready_i)
                        state_d = DIV_ST_IDLE;
                default:
                    state_d = DIV_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        res_d    = res_q;
        rd_d     = rd_q;
        is_rem_d = is_rem_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        if (state_q == DIV_ST_IDLE && accept) begin
            rd_d     = ix_div_inf_i.rd;
            is_rem_d = is_rem;
            dvd_d    = abs_op(ix_div_inf_i.rs1, sgn);
            dvs_d    = abs_op(ix_div_inf_i.rs2, sgn);
            rem_d    = '0;
            quo_d    = '0;
            cnt_d    = CNT_LOAD;
            neg_q_d  = sgn && (ix_div_inf_i.rs1[XLEN-1] ^ ix_div_inf_i.rs2[XLEN-1])
                           && !div_zero;
            neg_r_d  = sgn && ix_div_inf_i.rs1[XLEN-1];
            if (special)
                res_d = spec_res;
        end else if (state_q == DIV_ST_CALC) begin
            rem_d = step_rem;
            dvd_d = step_dvd;
            quo_d = step_q;
            cnt_d = cnt_q - 1'b1;
        end else if (state_q == DIV_ST_FIXUP) begin
            if (is_rem_q)
                res_d = neg_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
            else
                res_d = neg_q_q ? -quo_q : quo_q;
        end
    end

    always_comb begin
        ix_div_ready_o = (state_q == DIV_ST_IDLE);
        div_wb_valid_o = (state_q == DIV_ST_DONE);
        busy_o         = (state_q != DIV_ST_IDLE);
        div_wb_inf_o   = '{rd: rd_q, result: res_q};
    end

endmodule

// File: tb/tb_div_pipe.sv
// Self-checking bench for div_pipe: a fast-special and an iterative-only
// instance driven side by side and compared against an arithmetic model.
module tb_div_pipe;
    import div_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    ix_div_inf_t inf;
    logic        vin   [2];
    logic        wrdy  [2];
    logic        rdy_o [2];
    logic        wv    [2];
    logic        busy  [2];
    div_wb_inf_t winf  [2];

    int cmp = 0;
    int bad = 0;

    always #5 clk = ~clk;

    div_pipe #(.FAST_SPECIAL(1'b1)) u_fast (
        .clk            (clk),
        .rst            (rst),
        .ix_div_valid_i (vin[0]),
        .ix_div_ready_o (rdy_o[0]),
        .ix_div_inf_i   (inf),
        .flush_i        (flush),
        .div_wb_valid_o (wv[0]),
        .div_wb_ready_i (wrdy[0]),
        .div_wb_inf_o   (winf[0]),
        .busy_o         (busy[0])
    );

    div_pipe #(.FAST_SPECIAL(1'b0)) u_slow (
        .clk            (clk),
        .rst            (rst),
        .ix_div_valid_i (vin[1]),
        .ix_div_ready_o (rdy_o[1]),
        .ix_div_inf_i   (inf),
        .flush_i        (flush),
        .div_wb_valid_o (wv[1]),
        .div_wb_ready_i (wrdy[1]),
        .div_wb_inf_o   (winf[1]),
        .busy_o         (busy[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules.
    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (op[0]) begin
            q = a / b;
            r = a % b;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return op[1] ? r : q;
    endfunction

    function automatic bit is_special(input logic [1:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic chk_reset(input string tag);
        for (int u = 0; u < 2; u++)
            chk(tag, {rdy_o[u], wv[u], busy[u], winf[u]}, {3'b100, 37'h0});
    endtask

    // Called at a negedge. Accepts, waits for valid, checks, holds, retires.
    task automatic run_op(input int u, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int exp_lat,
                          input int hold);
        int          n;
        logic        early;
        div_wb_inf_t snap;
        logic [31:0] exp;
        exp = model(op, a, b);
        inf = '{rd: rd, rs1: a, rs2: b, div_control: div_op_e'(op)};
        vin[u]  = 1'b1;
        wrdy[u] = 1'b0;
        chk("ready_idle", 64'(rdy_o[u]), 64'd1);
        @(posedge clk);
        #1 vin[u] = 1'b0;
        n     = 1;
        early = 1'b0;
        forever begin
            @(negedge clk);
            if (wv[u]) break;
            if (rdy_o[u] || !busy[u]) early = 1'b1;
            if (n >= 100) break;
            @(posedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        chk("valid", 64'(wv[u]), 64'd1);
        chk("result", 64'(winf[u].result), 64'(exp));
        chk("rd", 64'(winf[u].rd), 64'(rd));
        chk("busy_ready", {early, rdy_o[u], busy[u]}, 3'b001);
        snap = winf[u];
        repeat (hold) begin
            @(negedge clk);
            chk("hold", {wv[u], rdy_o[u], winf[u]}, {2'b10, snap});
        end
        wrdy[u] = 1'b1;
        @(posedge clk);
        #1 wrdy[u] = 1'b0;
        @(negedge clk);
        chk("retire", {wv[u], rdy_o[u], busy[u]}, 3'b010);
    endtask

    logic [1:0]  t_op [8] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd3, 2'd0, 2'd2};
    logic [31:0] t_a  [8] = '{32'd100, 32'hFFFF_FF9C, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678,
                              32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b  [8] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        logic        seen;
        int          lat;
        rst   = 1'b1;
        flush = 1'b0;
        inf   = '0;
        for (int u = 0; u < 2; u++) begin
            vin[u]  = 1'b0;
            wrdy[u] = 1'b0;
        end
        #2 chk_reset("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // directed table on both instances
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 8; i++) begin
                lat = (u == 0 && is_special(t_op[i], t_a[i], t_b[i])) ? 1 : 34;
                run_op(u, t_op[i], t_a[i], t_b[i], 5'(5 + i), lat, 0);
            end

        // backpressure in DONE then back-to-back accept
        run_op(0, 2'd0, 32'd1000, 32'd9, 5'd3, 34, 10);
        run_op(0, 2'd2, 32'd1000, 32'd9, 5'd4, 34, 0);

        // random operands with occasional special values
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 12; i++) begin
                op = 2'($urandom_range(0, 3));
                a  = $urandom;
                b  = $urandom;
                case ($urandom_range(0, 5))
                    0: b = 0;
                    1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    2: b = 32'($urandom_range(1, 15));
                    3: a = 32'($urandom_range(0, 100));
                    default: ;
                endcase
                lat = (u == 0 && is_special(op, a, b)) ? 1 : 34;
                run_op(u, op, a, b, 5'($urandom_range(0, 31)), lat, 0);
            end

        // flush in CALC cycle 10
        inf = '{rd: 5'd7, rs1: 32'd1000, rs2: 32'd3, div_control: DIV_OP_DIV};
        vin[0] = 1'b1;
        @(posedge clk);
        #1 vin[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_state", {wv[0], rdy_o[0], busy[0]}, 3'b010);
        // request alongside flush is dropped
        @(negedge clk);
        vin[1] = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        #1 begin vin[1] = 1'b0; flush = 1'b0; end
        chk("flush_noaccept", {rdy_o[1], busy[1]}, 2'b10);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= wv[0] | wv[1];
        end
        chk("flush_novalid", 64'(seen), 64'd0);
        run_op(0, 2'd0, 32'd9, 32'd3, 5'd2, 34, 0);

        // async reset in CALC cycle 20
        inf = '{rd: 5'd9, rs1: 32'd77777, rs2: 32'd5, div_control: DIV_OP_DIVU};
        vin[1] = 1'b1;
        @(posedge clk);
        #1 vin[1] = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_reset("midop_reset");
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= wv[0] | wv[1];
        end
        chk("reset_novalid", 64'(seen), 64'd0);
        run_op(1, 2'd3, 32'd77777, 32'd5, 5'd9, 34, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
